datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq_if.sv | 38 +++
 rtl/datapath_seq.sv | 194 +++++++++++++++++++
 tb/tb_datapath_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// Bus bundle for datapath_seq: operation request fields, external register load port,
// and the busy/done/result/status outputs.
interface datapath_seq_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int RW    = $clog2(NREG)
);
    logic             start;
    logic [1:0]       op;
    logic [1:0]       shift;
    logic [RW-1:0]    rn;
    logic [RW-1:0]    rm;
    logic [RW-1:0]    rd;
    logic             asel;
    logic             bsel;
    logic [WIDTH-1:0] imm;
    logic             wb;
    logic             setflags;
    logic             ext_write;
    logic [RW-1:0]    ext_wnum;
    logic [WIDTH-1:0] ext_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] C;
    logic [2:0]       status;

    modport master (
        output start, op, shift, rn, rm, rd, asel, bsel, imm, wb, setflags,
        output ext_write, ext_wnum, ext_data,
        input  busy, done, C, status
    );

    modport slave (
        input  start, op, shift, rn, rm, rd, asel, bsel, imm, wb, setflags,
        input  ext_write, ext_wnum, ext_data,
        output busy, done, C, status
    );
endinterface

// File: rtl/datapath_seq.sv
// Multi-cycle register-file ALU: IDLE->LOADA->LOADB->EXEC->WRITE, one operation at a time.
// Optional macro DATAPATH_SEQ_SAT_EN: ADD/SUB overflow saturates C to signed max/min.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int RW    = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    datapath_seq_if.slave bus
);
    localparam int MSB   = WIDTH - 1;
    localparam int DEPTH = 1 << RW;

    typedef enum logic [2:0] {S_IDLE, S_LOADA, S_LOADB, S_EXEC, S_WRITE} state_t;

    state_t state_q, state_d;
    logic   busy, done;

    logic [1:0]       op_q, shift_q;
    logic [RW-1:0]    rn_q, rm_q, rd_q;
    logic             asel_q, bsel_q, wb_q, setflags_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [2:0]       status_q;
    logic [WIDTH-1:0] regs_q [NREG];

    logic [WIDTH-1:0] reg_rd [DEPTH];
    logic             we;
    logic [RW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    logic signed [WIDTH-1:0] ain, bin, res;
    logic                    v_ovf;

    function automatic logic signed [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] b,
                                                        input logic [1:0]       sh);
        case (sh)
            2'b01:   return {b[WIDTH-2:0], 1'b0};
            2'b10:   return {1'b0, b[WIDTH-1:1]};
            2'b11:   return {b[WIDTH-1], b[WIDTH-1:1]};
            default: return b;
        endcase
    endfunction

`ifdef DATAPATH_SEQ_SAT_EN
    // Overflow direction follows A's sign for both ADD and SUB.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] r,
                                                         input logic                    ovf,
                                                         input logic                    a_neg);
        if (!ovf)
            return r;
        return a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.start)
                    state_d = S_LOADA;
            end
            S_LOADA: state_d = S_LOADB;
            S_LOADB: state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= '0;
            shift_q    <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            imm_q      <= '0;
            wb_q       <= 1'b0;
            setflags_q <= 1'b0;
        end else if (state_q == S_IDLE && bus.start) begin
            op_q       <= bus.op;
            shift_q    <= bus.shift;
            rn_q       <= bus.rn;
            rm_q       <= bus.rm;
            rd_q       <= bus.rd;
            asel_q     <= bus.asel;
            bsel_q     <= bus.bsel;
            imm_q      <= bus.imm;
            wb_q       <= bus.wb;
            setflags_q <= bus.setflags;
        end
    end

    // Indices beyond NREG land on entries that stay zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            reg_rd[i] = '0;
        for (int i = 0; i < NREG; i++)
            reg_rd[i] = regs_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state_q == S_LOADA) begin
            a_q <= reg_rd[rn_q];
        end else if (state_q == S_LOADB) begin
            b_q <= reg_rd[rm_q];
        end
    end

    always_comb begin
        ain   = asel_q ? '0 : a_q;
        bin   = bsel_q ? imm_q : shift_b(b_q, shift_q);
        res   = '0;
        v_ovf = 1'b0;
        case (op_q)
            2'b00: begin
                res   = ain + bin;
                v_ovf = (ain[MSB] == bin[MSB]) && (res[MSB] != ain[MSB]);
            end
            2'b01: begin
                res   = ain - bin;
                v_ovf = (ain[MSB] != bin[MSB]) && (res[MSB] != ain[MSB]);
            end
            2'b10:   res = ain & bin;
            default: res = ~bin;
        endcase
`ifdef DATAPATH_SEQ_SAT_EN
        res = saturate(res, v_ovf, ain[MSB]);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q      <= '0;
            status_q <= '0;
        end else if (state_q == S_EXEC) begin
            c_q <= res;
            if (setflags_q)
                status_q <= {res[MSB], v_ovf, (res == '0)};
        end
    end

    // Result write-back owns the port in WRITE; external loads only in IDLE.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state_q == S_WRITE && wb_q) begin
            we    = 1'b1;
            waddr = rd_q;
            wdata = c_q;
        end else if (state_q == S_IDLE && bus.ext_write) begin
            we    = 1'b1;
            waddr = bus.ext_wnum;
            wdata = bus.ext_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < NREG; i++)
                if (waddr == RW'(i))
                    regs_q[i] <= wdata;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.C      = c_q;
    assign bus.status = status_q;
endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: directed cases plus randomized operations checked
// against an arithmetic reference model.
module tb_datapath_seq;
    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int RW    = 3;
    localparam int MOD   = 1 << WIDTH;
    localparam int HALF  = 1 << (WIDTH - 1);

`ifdef DATAPATH_SEQ_SAT_EN
    localparam int OVF_C  = 'h7FFF;
    localparam int OVF_ST = 3'b010;
`else
    localparam int OVF_C  = 'h8000;
    localparam int OVF_ST = 3'b110;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    datapath_seq_if #(.WIDTH(WIDTH), .NREG(NREG), .RW(RW)) dif ();

    datapath_seq #(.WIDTH(WIDTH), .NREG(NREG), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int st;
    } exp_t;

    exp_t sbq[$];
    int   mregs[NREG];
    int   mstat;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference model: signed-integer arithmetic on the operand values.
    function automatic exp_t model_op(input int op, input int shift, input int rn, input int rm,
                                      input int rd, input int asel, input int bsel, input int imm,
                                      input int wb, input int sf);
        int   a, b, r, sa, sb, full, v;
        exp_t e;
        a = asel ? 0 : mregs[rn];
        r = mregs[rm];
        if (bsel)
            b = imm;
        else
            case (shift)
                0:       b = r;
                1:       b = (r * 2) % MOD;
                2:       b = r / 2;
                default: b = r / 2 + ((r >= HALF) ? HALF : 0);
            endcase
        sa   = (a >= HALF) ? a - MOD : a;
        sb   = (b >= HALF) ? b - MOD : b;
        v    = 0;
        full = 0;
        case (op)
            0: begin
                full = sa + sb;
                r    = (a + b) % MOD;
                v    = (full >= HALF || full < -HALF) ? 1 : 0;
            end
            1: begin
                full = sa - sb;
                r    = (a - b + MOD) % MOD;
                v    = (full >= HALF || full < -HALF) ? 1 : 0;
            end
            2:       r = a & b;
            default: r = MOD - 1 - b;
        endcase
`ifdef DATAPATH_SEQ_SAT_EN
        if (v != 0)
            r = (full > 0) ? HALF - 1 : HALF;
`endif
        if (sf != 0)
            mstat = ((r >= HALF) ? 4 : 0) | ((v != 0) ? 2 : 0) | ((r == 0) ? 1 : 0);
        if (wb != 0)
            mregs[rd] = r;
        e.c  = r;
        e.st = mstat;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && dif.done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got done=1, expected no pending operation");
            end else begin
                e = sbq.pop_front();
                check("sb_C", 32'(dif.C), e.c);
                check("sb_status", 32'(dif.status), e.st);
            end
        end
    end

    task automatic ext_load(input int n, input int d);
        @(negedge clk);
        dif.ext_write = 1'b1;
        dif.ext_wnum  = RW'(n);
        dif.ext_data  = WIDTH'(d);
        mregs[n]      = d;
        @(negedge clk);
        dif.ext_write = 1'b0;
    endtask

    task automatic run_op(input int op, input int shift, input int rn, input int rm, input int rd,
                          input int asel, input int bsel, input int imm, input int wb, input int sf,
                          input int ew, input int ewn, input int ewd, input int noise);
        int lat;
        @(negedge clk);
        dif.op        = 2'(op);
        dif.shift     = 2'(shift);
        dif.rn        = RW'(rn);
        dif.rm        = RW'(rm);
        dif.rd        = RW'(rd);
        dif.asel      = asel[0];
        dif.bsel      = bsel[0];
        dif.imm       = WIDTH'(imm);
        dif.wb        = wb[0];
        dif.setflags  = sf[0];
        dif.ext_write = ew[0];
        dif.ext_wnum  = RW'(ewn);
        dif.ext_data  = WIDTH'(ewd);
        dif.start     = 1'b1;
        if (ew != 0)
            mregs[ewn] = ewd;
        sbq.push_back(model_op(op, shift, rn, rm, rd, asel, bsel, imm, wb, sf));
        @(negedge clk);
        // Captured fields must be immune to these changes; noise also retries start/ext_write.
        dif.start     = noise[0];
        dif.ext_write = noise[0];
        dif.ext_wnum  = RW'($urandom);
        dif.ext_data  = WIDTH'($urandom);
        dif.op        = 2'($urandom);
        dif.shift     = 2'($urandom);
        dif.rn        = RW'($urandom);
        dif.rm        = RW'($urandom);
        dif.rd        = RW'($urandom);
        dif.asel      = 1'($urandom);
        dif.bsel      = 1'($urandom);
        dif.imm       = WIDTH'($urandom);
        dif.wb        = 1'($urandom);
        dif.setflags  = 1'($urandom);
        lat = 1;
        while (!dif.done && lat < 8) begin
            check("busy_during_op", 32'(dif.busy), 1);
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, 4);
        dif.start     = 1'b0;
        dif.ext_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREG; i++)
            mregs[i] = 0;
        mstat         = 0;
        dif.start     = 1'b0;
        dif.op        = '0;
        dif.shift     = '0;
        dif.rn        = '0;
        dif.rm        = '0;
        dif.rd        = '0;
        dif.asel      = 1'b0;
        dif.bsel      = 1'b0;
        dif.imm       = '0;
        dif.wb        = 1'b0;
        dif.setflags  = 1'b0;
        dif.ext_write = 1'b0;
        dif.ext_wnum  = '0;
        dif.ext_data  = '0;

        #1;
        check("rst_busy", 32'(dif.busy), 0);
        check("rst_done", 32'(dif.done), 0);
        check("rst_C", 32'(dif.C), 0);
        check("rst_status", 32'(dif.status), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        ext_load(0, 7);
        ext_load(1, 2);
        run_op(0, 1, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("add_lsl_C", 32'(dif.C), 11);
        run_op(0, 0, 2, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("readback_R2", 32'(dif.C), 11);

        run_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("sub_zero_C", 32'(dif.C), 0);
        check("sub_zero_status", 32'(dif.status), 3'b001);

        ext_load(0, 'h7FFF);
        run_op(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        check("ovf_C", 32'(dif.C), OVF_C);
        check("ovf_status", 32'(dif.status), OVF_ST);

        run_op(3, 0, 0, 0, 0, 1, 1, 'hFFF0, 0, 0, 0, 0, 0, 0);
        check("not_C", 32'(dif.C), 'h000F);
        check("not_status_held", 32'(dif.status), OVF_ST);

        run_op(0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        run_op(0, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("busy_ext_ignored_R1", 32'(dif.C), 2);

        run_op(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 3, 5, 0);
        check("ext_same_cycle_C", 32'(dif.C), 10);

        // Abort an operation in EXEC with reset; nothing is queued for it.
        ext_load(5, 'h55);
        @(negedge clk);
        dif.op = 2'd0; dif.shift = 2'd0; dif.rn = 3'd5; dif.rm = 3'd5; dif.rd = 3'd5;
        dif.asel = 1'b0; dif.bsel = 1'b0; dif.wb = 1'b1; dif.setflags = 1'b1;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(dif.busy), 0);
        check("abort_done", 32'(dif.done), 0);
        check("abort_C", 32'(dif.C), 0);
        check("abort_status", 32'(dif.status), 0);
        for (int i = 0; i < NREG; i++)
            mregs[i] = 0;
        mstat = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        run_op(0, 0, 5, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("abort_R5_cleared", 32'(dif.C), 0);

        for (int n = 0; n < 60; n++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, NREG - 1)),
                   ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                   int'($urandom_range(0, MOD - 1)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
